dbus_timer: RTL and testbench
=============================

DBUS_TIMER -- requirements
Module: dbus_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF_0000, gives the 32-byte-aligned base address of the register window.
REQ-002 Port clk  input  1  is the single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  is the reset: synchronous, active-high.
REQ-004 Port addr  input  32  is the data-bus byte address from the CPU (ALU result).
REQ-005 Port wdata  input  32  is the data-bus store data.
REQ-006 Port wren  input  4  is the byte-lane write enable; bit i qualifies wdata[8i+7:8i].
REQ-007 Port rdata  output  32  is the read data returned to the CPU in the same cycle.
REQ-008 Port irq  output  1  is the level interrupt request.

Function
REQ-009 The block SHALL be selected when addr[31:5] == BASE_ADDR[31:5]; the register offset SHALL be addr[4:2]; addr[1:0] SHALL be ignored.
REQ-010 The block SHALL decode this register map: 0 CTRL (bit0 EN, bit1 AUTO, bit2 IE, rest 0); 1 PRESCALE [15:0]; 2 LOAD [31:0]; 3 COUNT (read-only); 4 STATUS (bit0 EXP, write-1-to-clear); offsets 5-7 read 0, writes ignored.
REQ-011 A selected write SHALL update only the byte lanes whose wren bit is set; unimplemented bits SHALL read 0.
REQ-012 rdata SHALL be combinational from addr and register state (zero-wait read), and 32'h0 when the block is not selected.
REQ-013 The block SHALL implement the states IDLE, RUN and DONE.
REQ-014 A write that changes CTRL.EN from 0 to 1 SHALL, on that edge: COUNT<=LOAD, prescale counter<=0, state<=RUN.
REQ-015 A write of EN=1 while EN is already 1 SHALL NOT restart the count.
REQ-016 A write of EN=0 in RUN SHALL move the state to IDLE; COUNT SHALL hold its value.
REQ-017 In RUN, the prescale counter SHALL increment each cycle; when it equals PRESCALE it SHALL wrap to 0 and produce one tick.
REQ-018 On a tick with COUNT != 0, COUNT SHALL decrement by 1.
REQ-019 On a tick with COUNT == 0, EXP SHALL be set. With AUTO=1: COUNT<=LOAD and stay in RUN. With AUTO=0: EN<=0 (hardware clear) and state<=DONE.
REQ-020 The expiry period SHALL be (LOAD+1)*(PRESCALE+1) cycles from the EN-setting edge to the EXP-setting edge.
REQ-021 Writes to LOAD or PRESCALE during RUN SHALL take effect only at the next reload or restart; the in-flight prescale compare uses the live PRESCALE value.
REQ-022 If a STATUS write-1-to-clear and an expiry occur on the same edge, set SHALL win (EXP=1).
REQ-023 If a software write to CTRL and a hardware EN clear (REQ-019) occur on the same edge, the software write SHALL win.
REQ-024 From DONE, an EN 0->1 write SHALL behave as in REQ-014.
REQ-025 The counters SHALL wrap modulo 2^32 and 2^16 with no saturation.
REQ-026 irq SHALL equal EXP & IE, decoded from registers with no added latency.

Reset
REQ-027 While rst=1 at a clock edge, CTRL, PRESCALE, LOAD, COUNT, STATUS and the prescale counter SHALL become 0, and state SHALL become IDLE.
REQ-028 After reset, irq SHALL be 0 and every register SHALL read 0; rst SHALL override any simultaneous bus write.
REQ-029 Reset asserted mid-RUN SHALL abort the count with no EXP set.

Verification
REQ-030 Scenario: LOAD=3, PRESCALE=0, CTRL=32'h5 -> COUNT reads 3,2,1,0; EXP=1 and irq=1 on the 4th edge after the write; EN reads 0; state DONE.
REQ-031 Scenario: LOAD=1, PRESCALE=2, CTRL=32'h3 -> EXP sets after 6 cycles; COUNT reloads to 1; count continues; irq stays 0 (IE=0).
REQ-032 Scenario: write STATUS=1 on the same edge as an expiry -> EXP remains 1; a later write STATUS=1 -> EXP=0 and irq=0.
REQ-033 Scenario: write LOAD with wren=4'b0010, wdata=32'hAABBCCDD -> LOAD reads 32'h0000CC00.
REQ-034 Scenario: read at addr=BASE_ADDR+32 -> rdata=0; write at BASE_ADDR+20 -> no register change.
REQ-035 Scenario: rst=1 during RUN with COUNT=5 -> the next cycle all registers read 0, irq=0, and no expiry occurs while EN stays 0.

Source files
------------

// File: rtl/dbus_timer.sv
// Memory-mapped down-counting timer on the CPU data bus with a prescaler, auto-reload and level interrupt.
// Zero-wait combinational read; register writes and timer state update on the rising clock edge.
module dbus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wren,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic        ctrl_en;
    logic        ctrl_auto;
    logic        ctrl_ie;
    logic [15:0] prescale;
    logic [31:0] load;
    logic [31:0] count;
    logic        exp_flag;
    logic [15:0] pcnt;

    logic        sel;
    logic [2:0]  off;
    logic        wr_ctrl;
    logic        wr_pre;
    logic        wr_load;
    logic        clr_exp;
    logic        start;
    logic        stop;
    logic        tick;
    logic        expire;
    logic [31:0] pre_merged;
    logic [31:0] load_merged;
    logic        unused_bits;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        sel         = (addr[31:5] == BASE_ADDR[31:5]);
        off         = addr[4:2];
        wr_ctrl     = sel && (off == 3'd0) && wren[0];
        wr_pre      = sel && (off == 3'd1);
        wr_load     = sel && (off == 3'd2);
        clr_exp     = sel && (off == 3'd4) && wren[0] && wdata[0];
        start       = wr_ctrl && wdata[0] && !ctrl_en;
        stop        = wr_ctrl && !wdata[0] && ctrl_en;
        // A software stop on the same edge suppresses the tick entirely.
        tick        = (state == S_RUN) && !stop && (pcnt == prescale);
        expire      = tick && (count == 32'd0);
        pre_merged  = lane_merge({16'h0000, prescale}, wdata, wren);
        load_merged = lane_merge(load, wdata, wren);
        unused_bits = ^{addr[1:0], pre_merged[31:16]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
            prescale  <= 16'h0000;
            load      <= 32'h0000_0000;
            count     <= 32'h0000_0000;
            exp_flag  <= 1'b0;
            pcnt      <= 16'h0000;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= wdata[0];
                ctrl_auto <= wdata[1];
                ctrl_ie   <= wdata[2];
            end else if (expire && !ctrl_auto) begin
                ctrl_en <= 1'b0;
            end

            if (wr_pre) begin
                prescale <= pre_merged[15:0];
            end
            if (wr_load) begin
                load <= load_merged;
            end

            if (expire) begin
                exp_flag <= 1'b1;
            end else if (clr_exp) begin
                exp_flag <= 1'b0;
            end

            if (start) begin
                count <= load;
                pcnt  <= 16'h0000;
                state <= S_RUN;
            end else if (stop) begin
                state <= S_IDLE;
            end else if (state == S_RUN) begin
                if (tick) begin
                    pcnt <= 16'h0000;
                    if (count != 32'd0) begin
                        count <= count - 32'd1;
                    end else if (ctrl_auto || wr_ctrl) begin
                        // A CTRL write keeping EN=1 overrides the hardware clear, so keep counting.
                        count <= load;
                    end else begin
                        state <= S_DONE;
                    end
                end else begin
                    pcnt <= pcnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        rdata = 32'h0000_0000;
        if (sel) begin
            case (off)
                3'd0:    rdata = {29'd0, ctrl_ie, ctrl_auto, ctrl_en};
                3'd1:    rdata = {16'h0000, prescale};
                3'd2:    rdata = load;
                3'd3:    rdata = count;
                3'd4:    rdata = {31'd0, exp_flag};
                default: rdata = 32'h0000_0000;
            endcase
        end
    end

    assign irq = exp_flag & ctrl_ie;

endmodule

// File: tb/tb_dbus_timer.sv
// Bench for dbus_timer: directed scenarios plus random bus traffic against a behavioural register/timer model.
module tb_dbus_timer;

    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'd0;
    localparam logic [31:0] A_PRE  = BASE + 32'd4;
    localparam logic [31:0] A_LOAD = BASE + 32'd8;
    localparam logic [31:0] A_CNT  = BASE + 32'd12;
    localparam logic [31:0] A_STAT = BASE + 32'd16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wren;
    logic [31:0] rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: register contents plus remaining-count and prescale phase.
    bit          m_valid = 0;
    logic        m_en, m_auto, m_ie, m_exp;
    logic [15:0] m_pre, m_phase;
    logic [31:0] m_load, m_count;

    dbus_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .wren  (wren),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bytes_upd(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (cur & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:5] != BASE[31:5]) return 32'h0;
        case (a[4:2])
            3'd0:    return {29'd0, m_ie, m_auto, m_en};
            3'd1:    return {16'd0, m_pre};
            3'd2:    return m_load;
            3'd3:    return m_count;
            3'd4:    return {31'd0, m_exp};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_edge(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic        hit, ctrl_w, fire;
        logic [2:0]  o;
        logic [31:0] pre_w;
        logic        n_en;
        logic [31:0] n_count;
        logic [15:0] n_phase;
        if (r) begin
            {m_en, m_auto, m_ie, m_exp} = 4'b0;
            m_pre = 0; m_phase = 0; m_load = 0; m_count = 0;
            m_valid = 1;
            return;
        end
        hit     = (a[31:5] == BASE[31:5]);
        o       = a[4:2];
        ctrl_w  = hit && o == 3'd0 && be[0];
        fire    = 0;
        n_en    = ctrl_w ? d[0] : m_en;
        n_count = m_count;
        n_phase = m_phase;
        if (ctrl_w && d[0] && !m_en) begin
            n_count = m_load;
            n_phase = 0;
        end else if (m_en && n_en) begin
            if (m_phase != m_pre) begin
                n_phase = m_phase + 16'd1;
            end else begin
                n_phase = 0;
                if (m_count != 0) n_count = m_count - 1;
                else begin
                    fire = 1;
                    if (m_auto || ctrl_w) n_count = m_load;
                    else n_en = 0;
                end
            end
        end
        if (ctrl_w) begin
            m_auto = d[1];
            m_ie   = d[2];
        end
        m_en = n_en;
        m_count = n_count;
        m_phase = n_phase;
        if (hit && o == 3'd1) begin
            pre_w = bytes_upd({16'd0, m_pre}, d, be);
            m_pre = pre_w[15:0];
        end
        if (hit && o == 3'd2) m_load = bytes_upd(m_load, d, be);
        if (fire) m_exp = 1;
        else if (hit && o == 3'd4 && be[0] && d[0]) m_exp = 0;
    endtask

    task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] obs, output logic obs_irq);
        @(negedge clk);
        rst = r; addr = a; wdata = d; wren = be;
        #1;
        obs = rdata;
        obs_irq = irq;
        if (!r && m_valid) begin
            chk("rdata_model", rdata, m_read(a));
            chk("irq_model", {31'd0, irq}, {31'd0, m_exp & m_ie});
        end
        @(posedge clk);
        m_edge(r, a, d, be);
    endtask

    logic [31:0] obs;
    logic        oirq;

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b0, a, d, be, obs, oirq);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, a, 32'h0, 4'h0, obs, oirq);
    endtask

    initial begin
        logic [31:0] exp_seq[4];
        int first;
        logic [31:0] a, d;
        logic [3:0]  be;
        logic        r;
        exp_seq = '{32'd3, 32'd2, 32'd1, 32'd0};

        cyc(1'b1, 32'h0, 32'h0, 4'h0, obs, oirq);
        cyc(1'b1, A_LOAD, 32'hFFFF_FFFF, 4'hF, obs, oirq);
        for (int i = 0; i < 8; i++) begin
            rd(BASE + 32'(4 * i));
            chk("reset_reg", obs, 32'h0);
        end
        chk("reset_irq", {31'd0, oirq}, 32'h0);

        // One-shot expiry with interrupt enabled
        wr(A_LOAD, 32'd3, 4'hF);
        wr(A_PRE, 32'd0, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        for (int i = 0; i < 4; i++) begin
            rd(A_CNT);
            chk("oneshot_count", obs, exp_seq[i]);
        end
        rd(A_STAT);
        chk("oneshot_exp", obs, 32'h1);
        chk("oneshot_irq", {31'd0, oirq}, 32'h1);
        rd(A_CTRL);
        chk("oneshot_ctrl", obs, 32'h4);
        wr(A_STAT, 32'h1, 4'hF);

        // Clear colliding with expiry: set wins
        wr(A_LOAD, 32'd1, 4'hF);
        wr(A_CTRL, 32'h7, 4'hF);
        rd(A_CNT);
        wr(A_STAT, 32'h1, 4'hF);
        rd(A_STAT);
        chk("w1c_collide", obs, 32'h1);
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_STAT, 32'h1, 4'hF);
        rd(A_STAT);
        chk("w1c_clear", obs, 32'h0);
        chk("w1c_irq", {31'd0, oirq}, 32'h0);

        // Auto-reload period with prescaler
        wr(A_PRE, 32'd2, 4'hF);
        wr(A_CTRL, 32'h3, 4'hF);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            rd(A_STAT);
            if (obs == 32'h1) begin
                first = k;
                break;
            end
        end
        chk("auto_period", 32'(first), 32'd7);
        rd(A_CNT);
        chk("auto_reload", obs, 32'd1);
        chk("auto_irq", {31'd0, oirq}, 32'h0);
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_STAT, 32'h1, 4'hF);

        // Byte lanes and address window
        wr(A_LOAD, 32'h0, 4'hF);
        wr(A_LOAD, 32'hAABB_CCDD, 4'b0010);
        rd(A_LOAD);
        chk("lane_load", obs, 32'h0000_CC00);
        rd(BASE + 32'd32);
        chk("outside_read", obs, 32'h0);
        wr(BASE + 32'd20, 32'hFFFF_FFFF, 4'hF);
        wr(BASE + 32'd32, 32'hFFFF_FFFF, 4'hF);
        rd(A_LOAD);
        chk("ignored_write", obs, 32'h0000_CC00);

        // Reset mid-run
        wr(A_LOAD, 32'd10, 4'hF);
        wr(A_PRE, 32'd0, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            rd(A_CNT);
            if (obs == 32'd5) begin
                first = k;
                break;
            end
        end
        chk("midrun_reach5", 32'(first), 32'd6);
        cyc(1'b1, A_CTRL, 32'h7, 4'hF, obs, oirq);
        for (int i = 0; i < 5; i++) begin
            rd(BASE + 32'(4 * i));
            chk("midrun_reset_reg", obs, 32'h0);
        end
        for (int i = 0; i < 20; i++) begin
            rd(A_STAT);
            chk("midrun_no_exp", obs, 32'h0);
        end

        // Random bus traffic
        for (int n = 0; n < 4000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            be = 4'($urandom);
            d  = $urandom;
            if ($urandom_range(0, 9) == 0) a = BASE + 32'd32 * 32'($urandom_range(1, 4)) + 32'($urandom_range(0, 31));
            else a = BASE + 32'($urandom_range(0, 31));
            if (a[4:2] == 3'd1 || a[4:2] == 3'd2) begin
                if ($urandom_range(0, 9) < 8) d = 32'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 9) < 5) be = 4'h0;
            cyc(r, a, d, be, obs, oirq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
